// File: rtl/pipe_decode_pkg.sv
// Shared LEGv8 decode definitions: opcodes, id_ctrl bit positions and the
// control-word decoder used by the decode stage.
package pipe_decode_pkg;

  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PREFIX = 8'b10110100;
  localparam logic [5:0]  OP_B_PREFIX   = 6'b000101;

  localparam int CTRL_W            = 10;
  localparam int CTRL_REG2_LOC     = 9;
  localparam int CTRL_UNCONDBRANCH = 8;
  localparam int CTRL_BRANCH       = 7;
  localparam int CTRL_MEM_READ     = 6;
  localparam int CTRL_MEM_TO_REG   = 5;
  localparam int CTRL_ALU_OP_HI    = 4;
  localparam int CTRL_ALU_OP_LO    = 3;
  localparam int CTRL_MEM_WRITE    = 2;
  localparam int CTRL_ALU_SRC      = 1;
  localparam int CTRL_REG_WRITE    = 0;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_D    = 2'd1,
    IMM_CB   = 2'd2,
    IMM_B    = 2'd3
  } imm_kind_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic              uses_rs2;
    imm_kind_t         imm_kind;
  } decode_t;

  function automatic decode_t decode_op(input logic [10:0] op);
    decode_t d;
    d.ctrl     = '0;
    d.illegal  = 1'b0;
    d.uses_rs2 = 1'b0;
    d.imm_kind = IMM_NONE;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      d.ctrl[CTRL_ALU_OP_HI] = 1'b1;
      d.ctrl[CTRL_REG_WRITE] = 1'b1;
      d.uses_rs2             = 1'b1;
    end else if (op == OP_LDUR) begin
      d.ctrl[CTRL_ALU_SRC]    = 1'b1;
      d.ctrl[CTRL_MEM_READ]   = 1'b1;
      d.ctrl[CTRL_MEM_TO_REG] = 1'b1;
      d.ctrl[CTRL_REG_WRITE]  = 1'b1;
      d.imm_kind              = IMM_D;
    end else if (op == OP_STUR) begin
      d.ctrl[CTRL_REG2_LOC]  = 1'b1;
      d.ctrl[CTRL_ALU_SRC]   = 1'b1;
      d.ctrl[CTRL_MEM_WRITE] = 1'b1;
      d.uses_rs2             = 1'b1;
      d.imm_kind             = IMM_D;
    end else if (op[10:3] == OP_CBZ_PREFIX) begin
      d.ctrl[CTRL_REG2_LOC]  = 1'b1;
      d.ctrl[CTRL_BRANCH]    = 1'b1;
      d.ctrl[CTRL_ALU_OP_LO] = 1'b1;
      d.uses_rs2             = 1'b1;
      d.imm_kind             = IMM_CB;
    end else if (op[10:5] == OP_B_PREFIX) begin
      d.ctrl[CTRL_UNCONDBRANCH] = 1'b1;
      d.imm_kind                = IMM_B;
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_decode_regfile_bypass.sv
// Register file with combinational reads, write-through bypass and an
// optional hard-wired zero register at the top index.
module regfile_bypass #(
  parameter int WORD        = 64,
  parameter int NUM_REGS    = 32,
  parameter int ZERO_REG_EN = 1,
  localparam int REG_ADDR   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_ADDR-1:0] read_addr1,
  input  logic [REG_ADDR-1:0] read_addr2,
  input  logic                write_en,
  input  logic [REG_ADDR-1:0] write_addr,
  input  logic [WORD-1:0]     write_data,
  output logic [WORD-1:0]     read_data1,
  output logic [WORD-1:0]     read_data2
);

  localparam logic [REG_ADDR-1:0] XZR = REG_ADDR'(NUM_REGS - 1);

  logic [WORD-1:0] regs [NUM_REGS];

  function automatic logic is_zero_reg(input logic [REG_ADDR-1:0] addr);
    return (ZERO_REG_EN != 0) && (addr == XZR);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_en && !is_zero_reg(write_addr)) begin
      regs[write_addr] <= write_data;
    end
  end

  // The zero register wins over the bypass so a write to it is never visible.
  always_comb begin
    read_data1 = regs[read_addr1];
    read_data2 = regs[read_addr2];
    if (write_en && write_addr == read_addr1) read_data1 = write_data;
    if (write_en && write_addr == read_addr2) read_data2 = write_data;
    if (is_zero_reg(read_addr1)) read_data1 = '0;
    if (is_zero_reg(read_addr2)) read_data2 = '0;
  end

endmodule

// File: rtl/pipe_decode.sv
// LEGv8 decode stage: field extraction, control decode, register read and
// the ID/EX pipeline register with load-use stall and flush bubbles.
module pipe_decode
  import pipe_decode_pkg::*;
#(
  parameter int WORD        = 64,
  parameter int NUM_REGS    = 32,
  parameter int ZERO_REG_EN = 1,
  localparam int REG_ADDR   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]      if_pc,
  input  logic                 flush,
  input  logic                 wb_reg_write,
  input  logic [REG_ADDR-1:0]  wb_write_reg,
  input  logic [WORD-1:0]      wb_write_data,
  output logic                 stall,
  output logic                 id_valid,
  output logic [WORD-1:0]      id_pc,
  output logic [WORD-1:0]      id_read_data1,
  output logic [WORD-1:0]      id_read_data2,
  output logic [WORD-1:0]      id_sign_ext,
  output logic [CTRL_W-1:0]    id_ctrl,
  output logic [10:0]          id_opcode,
  output logic [REG_ADDR-1:0]  id_rd,
  output logic                 id_illegal
);

  localparam logic [REG_ADDR-1:0] XZR = REG_ADDR'(NUM_REGS - 1);

  logic [10:0]         opcode;
  logic [REG_ADDR-1:0] rm, rn, rd, addr2;
  logic [WORD-1:0]     read_data1, read_data2, sign_ext;
  decode_t             dec;
  logic                bubble;

  assign opcode = instruction[31:21];
  assign rm     = REG_ADDR'(instruction[20:16]);
  assign rn     = REG_ADDR'(instruction[9:5]);
  assign rd     = REG_ADDR'(instruction[4:0]);
  assign dec    = decode_op(opcode);
  assign addr2  = dec.ctrl[CTRL_REG2_LOC] ? rd : rm;

  regfile_bypass #(
    .WORD       (WORD),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .read_addr1(rn),
    .read_addr2(addr2),
    .write_en  (wb_reg_write),
    .write_addr(wb_write_reg),
    .write_data(wb_write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  always_comb begin
    sign_ext = '0;
    case (dec.imm_kind)
      IMM_D:   sign_ext = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      IMM_CB:  sign_ext = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      IMM_B:   sign_ext = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      default: sign_ext = '0;
    endcase
  end

  // Load-use hazard against the load sitting in ID/EX; a flush squashes the
  // consumer anyway, so it suppresses the stall.
  assign stall = !reset && !flush && if_valid && id_valid &&
                 id_ctrl[CTRL_MEM_READ] && (id_rd != XZR) &&
                 ((rn == id_rd) || (dec.uses_rs2 && addr2 == id_rd));

  assign bubble = stall || flush || !if_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_read_data1 <= '0;
      id_read_data2 <= '0;
      id_sign_ext   <= '0;
      id_ctrl       <= '0;
      id_opcode     <= '0;
      id_rd         <= '0;
      id_illegal    <= 1'b0;
    end else begin
      id_valid      <= 1'b1;
      id_pc         <= if_pc;
      id_read_data1 <= read_data1;
      id_read_data2 <= read_data2;
      id_sign_ext   <= sign_ext;
      id_ctrl       <= dec.ctrl;
      id_opcode     <= opcode;
      id_rd         <= rd;
      id_illegal    <= dec.illegal;
    end
  end

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 The block SHALL have parameter WORD, default 64, datapath width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register-file depth; REG_ADDR = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter ZERO_REG_EN, default 1; when 1, register NUM_REGS-1 (XZR) reads 0 and ignores writes.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_valid  in  1  instruction/if_pc valid from fetch.
REQ-007 instruction  in  32  LEGv8 instruction word.
REQ-008 if_pc  in  WORD  PC of instruction.
REQ-009 flush  in  1  taken branch; squash the decode slot.
REQ-010 wb_reg_write  in  1  write-back enable.
REQ-011 wb_write_reg  in  REG_ADDR  write-back register number.
REQ-012 wb_write_data  in  WORD  write-back data.
REQ-013 stall  out  1  load-use hazard; fetch holds instruction/if_pc.
REQ-014 id_valid  out  1  ID/EX slot holds a real instruction.
REQ-015 id_pc, id_read_data1, id_read_data2, id_sign_ext  out  WORD each  registered PC, operands, immediate.
REQ-016 id_ctrl  out  10  {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}.
REQ-017 id_opcode  out  11; id_rd  out  REG_ADDR; id_illegal  out  1.

Function
REQ-018 Fields: opcode=[31:21], Rm=[20:16], Rn=[9:5], Rd/Rt=[4:0]; second read address SHALL be Rt when reg2_loc=1, else Rm.
REQ-019 Decode: R-format ADD/SUB/AND/ORR (10001011000/11001011000/10001010000/10101010000) -> alu_op=10, reg_write; LDUR 11111000010 -> alu_src, mem_read, mem_to_reg, reg_write, alu_op=00; STUR 11111000000 -> reg2_loc, alu_src, mem_write, alu_op=00; CBZ 10110100xxx -> reg2_loc, branch, alu_op=01; B 000101xxxxx -> uncondbranch.
REQ-020 Any other opcode SHALL give id_ctrl=0 and id_illegal=1 with id_valid following if_valid.
REQ-021 Immediate: LDUR/STUR imm9 [20:12], CBZ imm19 [23:5], B imm26 [25:0], each sign-extended to WORD; all others 0.
REQ-022 Register file SHALL write wb_write_data on the clock edge when wb_reg_write=1, except XZR when ZERO_REG_EN=1.
REQ-023 Reads are combinational with write-through bypass: a same-cycle write to the addressed register SHALL return wb_write_data; XZR reads 0 even if written.
REQ-024 All id_* outputs are registered; latency from instruction to id_* is exactly 1 cycle.
REQ-025 stall = if_valid & id_valid & id_ctrl.mem_read & (id_rd != XZR) & (Rn==id_rd | (uses 2nd read & addr2==id_rd)), combinational.
REQ-026 On stall or flush the ID/EX slot SHALL load a bubble: id_valid=0, id_ctrl=0, id_illegal=0; other id_* fields don't-care (implementation drives 0).
REQ-027 flush has priority: when flush=1, stall SHALL be 0.
REQ-028 if_valid=0 without stall/flush SHALL load a bubble identically to REQ-026.

Reset
REQ-029 On reset all id_* outputs and all registers SHALL be 0 immediately, independent of clk; stall=0 while reset asserted.
REQ-030 Reset deasserting mid-stream SHALL leave the first post-reset edge behaving as a normal decode.

Structure
REQ-031 Opcode constants, id_ctrl bit positions, and INSTR_LEN=32 belong in the shared definitions header.
REQ-032 The register file SHALL be a sub-module, regfile_bypass, parametrised by WORD and NUM_REGS.

Verification
REQ-033 Reset: pulse reset between edges -> all id_* 0 at once; read X5 after reset -> 0.
REQ-034 Write-through: wb_write X3=0x1234 same cycle as ADD X1,X3,X2 -> id_read_data1=0x1234 next edge.
REQ-035 Load-use: LDUR X2,[X1,#8] then ADD X4,X2,X5 -> stall=1 one cycle, bubble in slot, ADD issued next cycle; id_sign_ext=8 for LDUR.
REQ-036 XZR: LDUR X31 then ADD using X31 -> stall=0; writing X31=0xFF then reading -> 0.
REQ-037 Flush+stall same cycle -> stall=0, bubble loaded; CBZ with imm19=-4 -> id_sign_ext=0xFFFF_FFFF_FFFF_FFFC.
REQ-038 Opcode 0x7FF with if_valid=1 -> id_illegal=1, id_ctrl=0, id_valid=1.
